// File: rtl/vr_pkg.sv
// Shared types and constants for the vr_source traffic generator.
package vr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } vr_src_state_t;

  localparam int unsigned LfsrWidth = 8;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [LfsrWidth-1:0] LfsrTapMask = 8'hB8;

  localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/vr_source_if.sv
// Valid/ready downstream stream carrying one D_WIDTH-bit word per handshake.
interface vr_source_if #(
  parameter int unsigned D_WIDTH = 6
) ();

  logic               down_valid;
  logic               down_ready;
  logic [D_WIDTH-1:0] down_data;

  modport master (
    output down_valid,
    output down_data,
    input  down_ready
  );

  modport slave (
    input  down_valid,
    input  down_data,
    output down_ready
  );

endinterface

// File: rtl/lfsr8.sv
// Seeded 8-bit Fibonacci LFSR used to draw inter-word gaps; steps when en_i is high.
module lfsr8
  import vr_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] lfsr_o
);

  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
  logic                 feedback;

  always_comb begin
    feedback = ^(lfsr_q & LfsrTapMask);
    lfsr_d   = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[LfsrWidth-2:0], feedback};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/vr_source.sv
// Burst traffic source: emits COUNT incrementing words on a valid/ready port per start pulse.
// Optional random inter-word gaps are enabled with the VR_SOURCE_GAPS_EN macro.
module vr_source
  import vr_pkg::*;
#(
  parameter int unsigned          D_WIDTH  = 6,
  parameter int unsigned          COUNT    = 16,
  parameter logic [LfsrWidth-1:0] GAP_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [D_WIDTH-1:0]  base,
  vr_source_if.master         down,
  output logic                busy,
  output logic                done,
  output logic [CntWidth-1:0] sent_count
);

  localparam logic [CntWidth-1:0] CountLast = CntWidth'(COUNT);

  vr_src_state_t       state_q, state_d;
  logic [D_WIDTH-1:0]  data_q, data_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                handshake;
  logic                gap_draw;

`ifdef VR_SOURCE_GAPS_EN
  logic [LfsrWidth-1:0] lfsr;
  logic                 unused_lfsr;

  lfsr8 #(
    .Seed (GAP_SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  assign gap_draw    = lfsr[0];
  assign unused_lfsr = ^lfsr[LfsrWidth-1:1];
`else
  logic unused_seed;

  assign gap_draw    = 1'b0;
  assign unused_seed = ^GAP_SEED;
`endif

  // valid_q is a flop, so ready only ever gates the state update, never valid itself.
  assign handshake = valid_q & down.down_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = base;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (handshake) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CountLast) begin
            state_d = StDone;
          end else begin
            data_d = data_q + 1'b1;
            if (gap_draw) begin
              state_d = StGap;
            end
          end
        end
      end
      StGap:   state_d = StSend;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StSend);
    busy_d  = (state_d == StSend) || (state_d == StGap);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign down.down_valid = valid_q;
  assign down.down_data  = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sent_count      = cnt_q;

endmodule

// File: tb/tb_vr_source.sv
// Directed bench for vr_source with a scoreboard of expected words checked on each handshake.
module tb_vr_source;
  import vr_pkg::*;

  localparam int unsigned DW    = 6;
  localparam int unsigned CNT   = 16;
  localparam int          Limit = 200;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [DW-1:0]       base = '0;
  logic                busy;
  logic                done;
  logic [CntWidth-1:0] sent_count;

  vr_source_if #(.D_WIDTH(DW)) down_if ();

  vr_source #(
    .D_WIDTH  (DW),
    .COUNT    (CNT),
    .GAP_SEED (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .down       (down_if.master),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int            tests  = 0;
  int            failed = 0;
  logic [DW-1:0] exp_q[$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [DW-1:0] b);
    for (int i = 0; i < CNT; i++) begin
      logic [DW-1:0] w;
      w = b + DW'(i);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < Limit) begin
      tick();
      cyc++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!down_if.down_valid && cyc < Limit) begin
      tick();
      cyc++;
    end
    if (!down_if.down_valid) check("valid_timeout", 32'(down_if.down_valid), 32'd1);
  endtask

  // Mid-cycle monitor: stable-word rule and in-order scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("held_valid", 32'(down_if.down_valid), 32'd1);
        check("held_data", 32'(down_if.down_data), 32'(prev_data));
      end
      if (down_if.down_valid && down_if.down_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(down_if.down_data), 32'hFFFF_FFFF);
        end else begin
          check("word", 32'(down_if.down_data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = down_if.down_valid & ~down_if.down_ready;
      prev_data = down_if.down_data;
    end
  end

  initial begin
    int cyc;
    logic [DW-1:0] held;
    down_if.down_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 32'(down_if.down_valid), 0);
    check("rst_data", 32'(down_if.down_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(sent_count), 0);
    tick();
    rst = 1'b1;
    tick();

    // Full throughput, base 5
    down_if.down_ready = 1'b1;
    base  = 6'd5;
    start = 1'b1;
    push_burst(6'd5);
    tick();
    start = 1'b0;
    check("tp_first_valid", 32'(down_if.down_valid), 1);
    check("tp_first_data", 32'(down_if.down_data), 5);
    check("tp_busy", 32'(busy), 1);
    check("tp_count0", 32'(sent_count), 0);
    wait_done(cyc);
`ifndef VR_SOURCE_GAPS_EN
    check("tp_cycles", 32'(cyc), CNT);
`endif
    check("tp_done_valid", 32'(down_if.down_valid), 0);
    check("tp_done_busy", 32'(busy), 0);
    check("tp_count", 32'(sent_count), CNT);
    tick();
    check("tp_done_pulse", 32'(done), 0);
    check("tp_drained", 32'(exp_q.size()), 0);

    // Backpressure on the second word, restarting right after done
    down_if.down_ready = 1'b0;
    base  = 6'd10;
    start = 1'b1;
    push_burst(6'd10);
    tick();
    start = 1'b0;
    wait_valid();
    check("bp_word1", 32'(down_if.down_data), 10);
    down_if.down_ready = 1'b1;
    tick();
    down_if.down_ready = 1'b0;
    wait_valid();
    held = down_if.down_data;
    check("bp_word2", 32'(held), 11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(down_if.down_valid), 1);
      check("bp_hold_data", 32'(down_if.down_data), 32'(held));
      check("bp_hold_count", 32'(sent_count), 1);
    end
    down_if.down_ready = 1'b1;
    wait_done(cyc);
    check("bp_count", 32'(sent_count), CNT);
    tick();
    check("bp_drained", 32'(exp_q.size()), 0);

    // Wrap-around from 62
    base  = 6'd62;
    start = 1'b1;
    push_burst(6'd62);
    tick();
    start = 1'b0;
    check("wrap_first", 32'(down_if.down_data), 62);
    wait_done(cyc);
    check("wrap_count", 32'(sent_count), CNT);
    check("wrap_last_data", 32'(down_if.down_data), 13);
    tick();
    check("wrap_drained", 32'(exp_q.size()), 0);

    // Reset after 7 handshakes
    base  = 6'd3;
    start = 1'b1;
    push_burst(6'd3);
    tick();
    start = 1'b0;
    cyc = 0;
    while (sent_count != 16'd7 && cyc < Limit) begin
      tick();
      cyc++;
    end
    check("mid_reached7", 32'(sent_count), 7);
    rst = 1'b0;
    #1;
    check("mid_valid", 32'(down_if.down_valid), 0);
    check("mid_data", 32'(down_if.down_data), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_count", 32'(sent_count), 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    base  = 6'd40;
    start = 1'b1;
    push_burst(6'd40);
    tick();
    start = 1'b0;
    check("restart_data", 32'(down_if.down_data), 40);
    check("restart_count", 32'(sent_count), 0);
    wait_done(cyc);
    check("restart_final", 32'(sent_count), CNT);
    tick();
    check("restart_drained", 32'(exp_q.size()), 0);

    // start pulses during SEND and during DONE are ignored
    base  = 6'd20;
    start = 1'b1;
    push_burst(6'd20);
    tick();
    start = 1'b0;
    tick();
    tick();
    base  = 6'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_data", 32'(down_if.down_data), 23);
    wait_done(cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_valid", 32'(down_if.down_valid), 0);
    check("done_start_busy", 32'(busy), 0);
    check("done_start_count", 32'(sent_count), CNT);
    tick();
    check("done_start_idle", 32'(down_if.down_valid), 0);
    check("busy_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
